// File: rtl/mem_interface.sv
// Memory-side stage: captures the bus into MAR/MDR and runs a req/ack handshake with word-addressed RAM.
// Optional REQ watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_interface #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [DATA_W-1:0] BusMuxOut,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              Read,
  input  logic              Write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_req,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] MAR_q,
  output logic [DATA_W-1:0] MDR_q,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int unsigned CNT_W = 8;

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("mem_interface: TIMEOUT must be within 1..255");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
`ifdef MEM_TIMEOUT_EN
  logic [CNT_W-1:0]  cnt_q, cnt_d;
`endif

  // State and datapath registers
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= IDLE;
      mar_q   <= '0;
      mdr_q   <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      we_q    <= we_d;
      err_q   <= err_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Next-state and register-load decode; any start strobe in IDLE blocks MAR/MDR loads
  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    we_d    = we_q;
    err_d   = err_q;
`ifdef MEM_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (Read && Write) begin
          err_d = 1'b1;
        end else if (Read || Write) begin
          state_d = REQ;
          we_d    = Write;
          err_d   = 1'b0;
`ifdef MEM_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else begin
          if (MARin) mar_d = BusMuxOut[ADDR_W-1:0];
          if (MDRin) mdr_d = BusMuxOut;
        end
      end
      REQ: begin
        if (mem_ack) begin
          state_d = DONE;
          if (!we_q) mdr_d = mem_rdata;
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registers or decodes of the registered state
  assign mem_addr  = mar_q;
  assign mem_wdata = mdr_q;
  assign MAR_q     = mar_q;
  assign MDR_q     = mdr_q;
  assign mem_we    = we_q;
  assign error     = err_q;
  assign mem_req   = (state_q == REQ);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_mem_interface.sv
// Directed bench for mem_interface; timeout checks apply when MEM_TIMEOUT_EN is defined.
module tb_mem_interface;

  logic        clock = 1'b0;
  logic        clear;
  logic [31:0] BusMuxOut;
  logic        MARin, MDRin, Read, Write;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [8:0]  MAR_q;
  logic [31:0] MDR_q;
  logic        busy, done, error;

  int n_chk = 0;
  int n_bad = 0;

  mem_interface #(.DATA_W(32), .ADDR_W(9), .TIMEOUT(15)) dut (
    .clock(clock), .clear(clear), .BusMuxOut(BusMuxOut),
    .MARin(MARin), .MDRin(MDRin), .Read(Read), .Write(Write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_req(mem_req), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .MAR_q(MAR_q), .MDR_q(MDR_q), .busy(busy), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs driven and outputs sampled 1 time unit after it
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  initial begin
    clear = 1'b1; BusMuxOut = '0; MARin = 0; MDRin = 0; Read = 0; Write = 0;
    mem_rdata = '0; mem_ack = 0;
    cyc(); cyc();
    clear = 1'b0;
    check("rst_req", 32'(mem_req), 0);
    check("rst_we", 32'(mem_we), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(error), 0);
    check("rst_mar", 32'(MAR_q), 0);
    check("rst_mdr", MDR_q, 0);

    // MAR truncation
    MARin = 1; BusMuxOut = 32'h0000_01A5; cyc(); MARin = 0;
    check("mar_trunc", 32'(MAR_q), 32'h1A5);
    check("addr_trunc", 32'(mem_addr), 32'h1A5);

    // Write with ack in third REQ cycle
    MARin = 1; BusMuxOut = 32'h10; cyc(); MARin = 0;
    MDRin = 1; BusMuxOut = 32'hDEAD_BEEF; cyc(); MDRin = 0;
    Write = 1; cyc(); Write = 0;
    check("wr_req1", 32'(mem_req), 1);
    check("wr_we", 32'(mem_we), 1);
    check("wr_wdata", mem_wdata, 32'hDEAD_BEEF);
    check("wr_addr", 32'(mem_addr), 32'h10);
    check("wr_busy", 32'(busy), 1);
    cyc();
    check("wr_req2", 32'(mem_req), 1);
    check("wr_done_early", 32'(done), 0);
    cyc();
    check("wr_req3", 32'(mem_req), 1);
    mem_ack = 1; mem_rdata = 32'h5555_5555; cyc(); mem_ack = 0;
    check("wr_done", 32'(done), 1);
    check("wr_req_off", 32'(mem_req), 0);
    check("wr_mdr", MDR_q, 32'hDEAD_BEEF);
    check("wr_err", 32'(error), 0);
    cyc();
    check("wr_done_once", 32'(done), 0);
    check("wr_idle", 32'(busy), 0);

    // Read with ack on first REQ cycle
    Read = 1; cyc(); Read = 0;
    check("rd_req", 32'(mem_req), 1);
    check("rd_we", 32'(mem_we), 0);
    mem_ack = 1; mem_rdata = 32'h1234_5678; cyc(); mem_ack = 0;
    check("rd_done", 32'(done), 1);
    check("rd_mdr", MDR_q, 32'h1234_5678);
    check("rd_we_done", 32'(mem_we), 0);
    cyc();
    check("rd_done_once", 32'(done), 0);

    // Simultaneous Read and Write
    Read = 1; Write = 1; cyc(); Read = 0; Write = 0;
    check("cf_err", 32'(error), 1);
    check("cf_req", 32'(mem_req), 0);
    check("cf_busy", 32'(busy), 0);
    cyc();
    check("cf_req_later", 32'(mem_req), 0);

    // MDRin and second Read during REQ are ignored
    Read = 1; cyc(); Read = 0;
    check("cf_err_clr", 32'(error), 0);
    MDRin = 1; BusMuxOut = 32'hFFFF_FFFF; cyc(); MDRin = 0;
    check("req_mdr_hold", MDR_q, 32'h1234_5678);
    Read = 1; cyc(); Read = 0;
    mem_ack = 1; mem_rdata = 32'hCAFE_F00D; cyc(); mem_ack = 0;
    check("req2_done", 32'(done), 1);
    check("req2_mdr", MDR_q, 32'hCAFE_F00D);
    cyc();
    check("no_queue_busy", 32'(busy), 0);
    cyc();
    check("no_queue_req", 32'(mem_req), 0);

    // MDRin with Read: load dropped, read data wins
    Read = 1; MDRin = 1; BusMuxOut = 32'hAAAA_AAAA; cyc(); Read = 0; MDRin = 0;
    check("mdrin_rd_drop", MDR_q, 32'hCAFE_F00D);
    mem_ack = 1; mem_rdata = 32'h0BAD_CAFE; cyc(); mem_ack = 0;
    check("mdrin_rd_data", MDR_q, 32'h0BAD_CAFE);
    cyc();

    // MARin with Write: start uses old MAR
    MARin = 1; Write = 1; BusMuxOut = 32'h1FF; cyc(); MARin = 0; Write = 0;
    check("marin_wr_addr", 32'(mem_addr), 32'h10);
    mem_ack = 1; cyc(); mem_ack = 0;
    check("marin_wr_mar", 32'(MAR_q), 32'h10);
    check("marin_wr_mdr", MDR_q, 32'h0BAD_CAFE);
    cyc();

    // Ack outside REQ is ignored
    mem_ack = 1; mem_rdata = 32'h7777_7777; cyc(); mem_ack = 0;
    check("idle_ack_busy", 32'(busy), 0);
    check("idle_ack_done", 32'(done), 0);
    check("idle_ack_mdr", MDR_q, 32'h0BAD_CAFE);

`ifdef MEM_TIMEOUT_EN
    begin
      int n;
      Read = 1; cyc(); Read = 0;
      n = 0;
      while (mem_req && n < 40) begin n++; cyc(); end
      check("to_cycles", 32'(n), 15);
      check("to_done", 32'(done), 1);
      check("to_err", 32'(error), 1);
      check("to_mdr", MDR_q, 32'h0BAD_CAFE);
      cyc();
      Read = 1; cyc(); Read = 0;
      for (int i = 1; i < 15; i++) cyc();
      check("to_ack_req15", 32'(mem_req), 1);
      mem_ack = 1; mem_rdata = 32'h0F0F_0F0F; cyc(); mem_ack = 0;
      check("to_ack_done", 32'(done), 1);
      check("to_ack_err", 32'(error), 0);
      check("to_ack_mdr", MDR_q, 32'h0F0F_0F0F);
      cyc();
    end
`else
    // Without the watchdog REQ waits indefinitely
    Read = 1; cyc(); Read = 0;
    for (int i = 0; i < 20; i++) cyc();
    check("wait_busy", 32'(busy), 1);
    check("wait_done", 32'(done), 0);
    check("wait_err", 32'(error), 0);
    mem_ack = 1; mem_rdata = 32'h0F0F_0F0F; cyc(); mem_ack = 0;
    check("wait_ack_mdr", MDR_q, 32'h0F0F_0F0F);
    cyc();
`endif

    // Clear during second REQ cycle
    Read = 1; cyc(); Read = 0;
    cyc();
    check("clr_pre_req", 32'(mem_req), 1);
    clear = 1; cyc(); clear = 0;
    check("clr_req", 32'(mem_req), 0);
    check("clr_busy", 32'(busy), 0);
    check("clr_mdr", MDR_q, 0);
    check("clr_done", 32'(done), 0);
    cyc();
    check("clr_no_done", 32'(done), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
